// File: rtl/sl3p_user_ctrl_arb.sv
// sl3p_user_ctrl_arb: round-robin sharing of the SerialLite III TX user-control sideband
module sl3p_user_ctrl_arb #(
  parameter int NUM_REQ = 4,
  parameter int LANES   = 2,
  parameter int CTRL_W  = LANES * 48,
  parameter int TO_BITS = 10
) (
  input  logic                      tx_clk,
  input  logic                      tx_arst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*CTRL_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      tx_halt,
  output logic [CTRL_W-1:0]         tx_user_ctrl,
  output logic                      tx_user_ctrl_req,
  input  logic                      tx_user_ctrl_ack,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [2:0]                timeout_id,
  output logic [7:0]                timeout_cnt
);
  typedef enum logic {IDLE, REQ} state_t;
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(2**TO_BITS - 2);
  state_t state;
  logic [2:0] ptr, win, nxt, nxt_inc, off;
  logic [3:0] sum;
  logic [NUM_REQ-1:0] win_oh, cand, rot;
  logic [CTRL_W-1:0] nxt_data;
  logic [TO_BITS-1:0] to_ctr;
  logic grant, done;

  // one-hot of the registered winner: drives req_ready and masks it out of back-to-back
  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) win_oh[i] = (win == 3'(i));
  end

  assign req_ready = (state == REQ && tx_user_ctrl_ack) ? win_oh : '0;
  assign busy = tx_user_ctrl_req;

  // round-robin search from ptr; grant in IDLE or on ack (back-to-back), never while halted
  always_comb begin
    cand = state == REQ ? req_valid & ~win_oh : req_valid;
    rot = NUM_REQ'({cand, cand} >> ptr);
    off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) if (rot[j]) off = 3'(j);
    sum = {1'b0, ptr} + {1'b0, off};
    nxt = sum >= 4'(NUM_REQ) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
    nxt_inc = nxt == 3'(NUM_REQ - 1) ? 3'd0 : nxt + 3'd1;
    nxt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) if (nxt == 3'(i)) nxt_data = req_data[i*CTRL_W +: CTRL_W];
    grant = |cand && !tx_halt && (state == IDLE || tx_user_ctrl_ack);
    done = state == REQ && (tx_user_ctrl_ack || to_ctr == TO_LAST);
  end

  // grant, hold until ack, back-to-back reload and ack-timeout abandonment (ack beats timeout)
  always_ff @(posedge tx_clk or negedge tx_arst_n) begin
    if (!tx_arst_n) begin
      state            <= IDLE;
      ptr              <= '0;
      win              <= '0;
      to_ctr           <= '0;
      tx_user_ctrl     <= '0;
      tx_user_ctrl_req <= 1'b0;
      timeout_err      <= 1'b0;
      timeout_id       <= '0;
      timeout_cnt      <= '0;
    end else begin
      timeout_err <= 1'b0;
      if (grant) begin
        state            <= REQ;
        win              <= nxt;
        ptr              <= nxt_inc;
        tx_user_ctrl     <= nxt_data;
        tx_user_ctrl_req <= 1'b1;
        to_ctr           <= '0;
      end else if (done) begin
        state            <= IDLE;
        tx_user_ctrl_req <= 1'b0;
        to_ctr           <= '0;
        if (!tx_user_ctrl_ack) begin
          timeout_err <= 1'b1;
          timeout_id  <= win;
          timeout_cnt <= timeout_cnt + 8'(timeout_cnt != 8'hff);
        end
      end else if (state == REQ) begin
        to_ctr <= to_ctr + TO_BITS'(1);
      end
    end
  end
endmodule
